// File: rtl/fp_merge_arb_pkg.sv
// Shared types for the two-input four-phase merge arbiter.
// Holds the handshake FSM state encoding and the default counter width.
package fp_merge_arb_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/fp_arb_rrsel.sv
// Two-way round-robin selector: on a tie the requester not granted last wins,
// otherwise the lone requester wins.
module fp_arb_rrsel (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/fp_merge_arb.sv
// Merges two four-phase requesters onto one downstream stage, forwarding or
// eliminating each granted packet according to its keep flag.
module fp_merge_arb
  import fp_merge_arb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             MR,
  input  logic             Send_in0,
  input  logic             Send_in1,
  input  logic             Exb0,
  input  logic             Exb1,
  output logic             Ack_out0,
  output logic             Ack_out1,
  output logic             Send_out,
  input  logic             Ack_in,
  output logic             Sel,
  output logic             CP,
  output logic [CNT_W-1:0] Elim_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic             sel_reg, sel_next;
  logic             last_reg, last_next;
  logic             cp_reg, cp_next;
  logic             send_reg, send_next;
  logic [1:0]       ack_reg, ack_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [1:0]       req;
  logic             grant;
  logic             exb_grant;
  logic             req_sel;

  assign req       = {Send_in1, Send_in0};
  assign exb_grant = grant ? Exb1 : Exb0;
  assign req_sel   = sel_reg ? Send_in1 : Send_in0;

  fp_arb_rrsel u_rrsel (
    .req   (req),
    .last  (last_reg),
    .grant (grant)
  );

  // last_reg resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      state_reg <= IDLE;
      sel_reg   <= 1'b0;
      last_reg  <= 1'b1;
      cp_reg    <= 1'b0;
      send_reg  <= 1'b0;
      ack_reg   <= 2'b00;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      cp_reg    <= cp_next;
      send_reg  <= send_next;
      ack_reg   <= ack_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    cp_next    = 1'b0;
    send_next  = send_reg;
    ack_next   = ack_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          sel_next  = grant;
          last_next = grant;
          cp_next   = 1'b1;
          if (exb_grant) begin
            state_next = SEND;
            send_next  = 1'b1;
          end else begin
            state_next = ACK;
            ack_next   = grant ? 2'b10 : 2'b01;
            if (cnt_reg != CNT_MAX) begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
      end
      SEND: begin
        if (Ack_in) begin
          state_next = ACK;
          send_next  = 1'b0;
          ack_next   = sel_reg ? 2'b10 : 2'b01;
        end
      end
      ACK: begin
        if (!req_sel && !Ack_in) begin
          state_next = IDLE;
          ack_next   = 2'b00;
        end
      end
      default: begin
        state_next = IDLE;
        send_next  = 1'b0;
        ack_next   = 2'b00;
      end
    endcase
  end

  assign Ack_out0 = ack_reg[0];
  assign Ack_out1 = ack_reg[1];
  assign Send_out = send_reg;
  assign Sel      = sel_reg;
  assign CP       = cp_reg;
  assign Elim_cnt = cnt_reg;

endmodule

// File: tb/tb_fp_merge_arb.sv
// Directed scoreboard bench for fp_merge_arb; a second instance with a 2-bit
// counter shares the stimulus to exercise counter saturation.
module tb_fp_merge_arb;

  logic       CLK = 1'b0;
  logic       MR, s0, s1, e0, e1, ack_in;
  logic       a0, a1, so, sel, cp;
  logic [7:0] cnt;
  logic       b_a0, b_a1, b_so, b_sel, b_cp;
  logic [1:0] b_cnt;

  always #5 CLK = ~CLK;

  fp_merge_arb dut (
    .CLK(CLK), .MR(MR), .Send_in0(s0), .Send_in1(s1), .Exb0(e0), .Exb1(e1),
    .Ack_out0(a0), .Ack_out1(a1), .Send_out(so), .Ack_in(ack_in),
    .Sel(sel), .CP(cp), .Elim_cnt(cnt)
  );

  fp_merge_arb #(.CNT_W(2)) dut_s (
    .CLK(CLK), .MR(MR), .Send_in0(s0), .Send_in1(s1), .Exb0(e0), .Exb1(e1),
    .Ack_out0(b_a0), .Ack_out1(b_a1), .Send_out(b_so), .Ack_in(ack_in),
    .Sel(b_sel), .CP(b_cp), .Elim_cnt(b_cnt)
  );

  typedef struct packed {
    logic sel;
    logic fwd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;
  int   exp_cnt_s = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    MR = 1'b1; s0 = 1'b0; s1 = 1'b0; ack_in = 1'b0;
    exp_cnt = 0; exp_cnt_s = 0;
    step();
    step();
    MR = 1'b0;
  endtask

  // One complete packet: request, grant, optional downstream handshake, release.
  task automatic packet(input logic r0, input logic r1, input logic exp_sel,
                        input logic keep, input int dly, input logic tie);
    exp_t got;
    bit   seen;
    int   n;
    logic ga, oa;
    s0 = r0; s1 = r1; e0 = keep; e1 = keep;
    sb.push_back('{sel: exp_sel, fwd: keep});
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      if (cp === 1'b1) seen = 1'b1;
    end
    chk("grant_seen", 32'(seen), 32'd1);
    if (!seen) begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "FAIL grant_timeout");
    end
    got = sb.pop_front();
    chk("sel", 32'(sel), 32'(got.sel));
    chk("send_out_at_grant", 32'(so), 32'(got.fwd));
    oa = got.sel ? a0 : a1;
    chk("ack_other_low", 32'(oa), 32'd0);
    // Disturb keep flags and the other request after the grant.
    e0 = ~keep; e1 = ~keep;
    if (!tie) begin s0 = 1'b1; s1 = 1'b1; end
    if (got.fwd) begin
      n = 1;
      for (int i = 0; i < dly; i++) begin
        step();
        ga = got.sel ? a1 : a0;
        chk("cp_single", 32'(cp), 32'd0);
        chk("send_hold", 32'(so), 32'd1);
        chk("ack_wait_low", 32'(ga), 32'd0);
        chk("sel_stable", 32'(sel), 32'(got.sel));
        if (so === 1'b1) n++;
      end
      ack_in = 1'b1;
      step();
      ga = got.sel ? a1 : a0;
      chk("send_out_drop", 32'(so), 32'd0);
      chk("ack_sel_high", 32'(ga), 32'd1);
      chk("send_cycles", 32'(n), 32'(dly + 1));
    end else begin
      ga = got.sel ? a1 : a0;
      chk("ack_sel_at_grant", 32'(ga), 32'd1);
      exp_cnt++;
      if (exp_cnt_s < 3) exp_cnt_s++;
      chk("elim_cnt", 32'(cnt), 32'(exp_cnt));
      chk("elim_cnt_sat", 32'(b_cnt), 32'(exp_cnt_s));
    end
    step();
    ga = got.sel ? a1 : a0;
    chk("ack_hold", 32'(ga), 32'd1);
    chk("send_stays_low", 32'(so), 32'd0);
    if (tie) begin
      if (got.sel) s1 = 1'b0; else s0 = 1'b0;
    end else begin
      s0 = 1'b0; s1 = 1'b0;
    end
    ack_in = 1'b0;
    step();
    chk("ack_release", 32'(a0 | a1), 32'd0);
    chk("no_grant_on_return", 32'(cp), 32'd0);
    $display("packet req=%b%b keep=%b dly=%0d sel=%b elim_cnt=%0d sat_cnt=%0d",
             r1, r0, keep, dly, sel, cnt, b_cnt);
  endtask

  initial begin
    MR = 1'b1; s0 = 1'b0; s1 = 1'b0; e0 = 1'b0; e1 = 1'b0; ack_in = 1'b0;
    #1;
    chk("rst_send_out", 32'(so), 32'd0);
    chk("rst_ack0", 32'(a0), 32'd0);
    chk("rst_ack1", 32'(a1), 32'd0);
    chk("rst_cp", 32'(cp), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    step();
    step();
    MR = 1'b0;

    packet(1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);   // forward from 0
    packet(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);   // eliminate from 1
    packet(1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b0);  // slow downstream
    packet(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);   // immediate ack

    do_reset();
    packet(1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    packet(1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1);
    packet(1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    packet(1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1);
    s0 = 1'b0; s1 = 1'b0;

    // Reset while a forwarded packet is waiting on the downstream ack.
    do_reset();
    s1 = 1'b1; e1 = 1'b1;
    step();
    chk("mid_grant_cp", 32'(cp), 32'd1);
    step();
    chk("mid_in_send", 32'(so), 32'd1);
    #2;
    MR = 1'b1;
    #1;
    chk("mid_rst_send_out", 32'(so), 32'd0);
    chk("mid_rst_ack", 32'({a1, a0}), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    s1 = 1'b0;
    step();
    MR = 1'b0;
    exp_cnt = 0; exp_cnt_s = 0;
    $display("reset mid SEND: send_out=%b ack=%b%b", so, a1, a0);
    packet(1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);   // pointer favours 0 again

    do_reset();
    for (int k = 0; k < 5; k++) begin
      packet(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
